// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT  = 64;
    localparam int unsigned DEPTH_DEFAULT = 4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0]             instr;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with async reset and a synchronous flush; head is read straight from storage.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             push_en;
    logic             pop_en;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        push_en = push && !full;
        pop_en  = pop && !empty;
        head    = mem[rd_ptr_q];
        count   = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC sequencing, fixed-latency imem requests, buffered delivery to decode.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     Instruction,
    output logic [XLEN-1:0] PC
);

    localparam int unsigned     CW       = $clog2(DEPTH) + 1;
    localparam int unsigned     OW       = CW + 1;
    localparam int unsigned     EW       = 32 + XLEN;
    localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] last_pc_q;
    logic            inflight_q;
    logic            squash_q;

    logic [CW-1:0]   count;
    logic            empty;
    entry_t          head;
    entry_t          wentry;
    logic            push;
    logic            pop;
    logic [OW-1:0]   occupancy;
    logic [OW-1:0]   limit;

    always_comb begin
        pop       = inst_valid && inst_ready;
        // A slot is reserved for every request still in flight.
        occupancy = OW'(count) + OW'(inflight_q);
        limit     = OW'(DEPTH) + OW'(pop);
        imem_req  = !Reset && !redirect && (occupancy < limit);
        imem_addr = fetch_pc_q;

        push         = inflight_q && !squash_q && !redirect;
        wentry.instr = imem_rdata;
        wentry.pc    = req_pc_q;

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_comb begin
        inst_valid  = !empty;
        Instruction = empty ? NOP_INSTR : head.instr;
        PC          = empty ? last_pc_q : head.pc;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc_q <= START_PC;
            req_pc_q   <= START_PC;
            last_pc_q  <= START_PC;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= imem_req;
            // Drop any response still attributed to the pre-redirect stream.
            squash_q   <= redirect;
            if (imem_req) begin
                req_pc_q <= fetch_pc_q;
            end
            if (pop) begin
                last_pc_q <= head.pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (Clk),
        .rst  (Reset),
        .flush(redirect),
        .push (push),
        .wdata(wentry),
        .pop  (pop),
        .head (head),
        .count(count),
        .empty(empty)
    );

endmodule
